// File: rtl/cpu_datapath_pkg.sv
// cpu_datapath_pkg: shared width, opcode encodings and result helper for the single-bus datapath.
package cpu_datapath_pkg;
    localparam int WIDTH = 32;
    typedef logic [WIDTH-1:0] word_t;
    typedef logic [2*WIDTH-1:0] dword_t;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    function automatic dword_t low_only(word_t x);
        return {{WIDTH{1'b0}}, x};
    endfunction
endpackage

// File: rtl/cpu_datapath_if.sv
// cpu_datapath_if: control strobes, memory/input-port data and observed bus/address of the datapath.
interface cpu_datapath_if;
    import cpu_datapath_pkg::*;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic        pc_in, hi_in, lo_in, mar_in, y_in, z_in, mdr_in, read, inc_pc, in_port_in;
    logic        pc_out, hi_out, lo_out, mdr_out, in_port_out, z_high_out, z_low_out;
    logic [4:0]  opcode;
    word_t       in_port_data, mdatain, bus_mux_out, mar_out;
    modport master (
        output r_in, r_out, pc_in, hi_in, lo_in, mar_in, y_in, z_in, mdr_in, read, inc_pc,
               in_port_in, pc_out, hi_out, lo_out, mdr_out, in_port_out, z_high_out, z_low_out,
               opcode, in_port_data, mdatain,
        input  bus_mux_out, mar_out
    );
    modport slave (
        input  r_in, r_out, pc_in, hi_in, lo_in, mar_in, y_in, z_in, mdr_in, read, inc_pc,
               in_port_in, pc_out, hi_out, lo_out, mdr_out, in_port_out, z_high_out, z_low_out,
               opcode, in_port_data, mdatain,
        output bus_mux_out, mar_out
    );
endinterface

// File: rtl/cpu_datapath_alu.sv
// cpu_alu: combinational ALU, A from Y and B from the bus, 64-bit result destined for Z.
module cpu_alu
    import cpu_datapath_pkg::*;
(
    input  word_t      a,
    input  word_t      b,
    input  logic [4:0] opcode,
    output dword_t     result
);
    logic [4:0] s;
    dword_t     rot_r, rot_l, prod;
    word_t      sra, quo, rem;
    assign s     = b[4:0];
    assign rot_r = {a, a} >> s;
    assign rot_l = {a, a} << s;
    // operands sign-extended explicitly so the product is a true signed 64-bit result
    assign prod  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign sra   = $signed(a) >>> s;
    assign quo   = $signed(a) / $signed(b);
    assign rem   = $signed(a) % $signed(b);
    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = low_only(a + b);
            OP_SUB:  result = low_only(a - b);
            OP_AND:  result = low_only(a & b);
            OP_OR:   result = low_only(a | b);
            OP_SHR:  result = low_only(a >> s);
            OP_SHRA: result = low_only(sra);
            OP_SHL:  result = low_only(a << s);
            OP_ROR:  result = low_only(rot_r[WIDTH-1:0]);
            OP_ROL:  result = low_only(rot_l[2*WIDTH-1:WIDTH]);
            OP_MUL:  result = prod;
            OP_DIV:  result = (b == '0) ? '0 : {rem, quo};
            OP_NEG:  result = low_only(-b);
            OP_NOT:  result = low_only(~b);
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/cpu_datapath_reg.sv
// cpu_datapath_reg: enabled register with asynchronous active-low clear.
module cpu_datapath_reg #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clock or negedge clear)
        if (!clear) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus 32-bit datapath; registers load from the shared bus, Z from the ALU.
module cpu_datapath
    import cpu_datapath_pkg::*;
(
    input  logic clock,
    input  logic clear,
    cpu_datapath_if.slave dp
);
    word_t  bus, pc, hi, lo, mar, mdr, y, inp;
    word_t  r [16];
    dword_t z, alu_res;
    for (genvar i = 0; i < 16; i++) begin : g_gp
        cpu_datapath_reg #(.W(WIDTH)) u_r (.clock, .clear, .en(dp.r_in[i]), .d(bus), .q(r[i]));
    end
    cpu_datapath_reg #(.W(WIDTH)) u_pc (
        .clock, .clear, .en(dp.pc_in | dp.inc_pc), .d(dp.pc_in ? bus : pc + 1'b1), .q(pc)
    );
    cpu_datapath_reg #(.W(WIDTH)) u_hi (.clock, .clear, .en(dp.hi_in), .d(bus), .q(hi));
    cpu_datapath_reg #(.W(WIDTH)) u_lo (.clock, .clear, .en(dp.lo_in), .d(bus), .q(lo));
    cpu_datapath_reg #(.W(WIDTH)) u_mar (.clock, .clear, .en(dp.mar_in), .d(bus), .q(mar));
    cpu_datapath_reg #(.W(WIDTH)) u_y (.clock, .clear, .en(dp.y_in), .d(bus), .q(y));
    cpu_datapath_reg #(.W(WIDTH)) u_mdr (
        .clock, .clear, .en(dp.mdr_in), .d(dp.read ? dp.mdatain : bus), .q(mdr)
    );
    cpu_datapath_reg #(.W(WIDTH)) u_inp (
        .clock, .clear, .en(dp.in_port_in), .d(dp.in_port_data), .q(inp)
    );
    cpu_datapath_reg #(.W(2*WIDTH)) u_z (.clock, .clear, .en(dp.z_in), .d(alu_res), .q(z));
    cpu_alu u_alu (.a(y), .b(bus), .opcode(dp.opcode), .result(alu_res));
    // later assignments win, so sources are listed from lowest to highest priority
    always_comb begin
        bus = '0;
        if (dp.in_port_out) bus = inp;
        if (dp.mdr_out) bus = mdr;
        if (dp.pc_out) bus = pc;
        if (dp.z_low_out) bus = z[WIDTH-1:0];
        if (dp.z_high_out) bus = z[2*WIDTH-1:WIDTH];
        if (dp.lo_out) bus = lo;
        if (dp.hi_out) bus = hi;
        for (int i = 15; i >= 0; i--)
            if (dp.r_out[i]) bus = r[i];
    end
    assign dp.bus_mux_out = bus;
    assign dp.mar_out     = mar;
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed register-transfer sequences plus random strobes against a behavioural model.
module tb_cpu_datapath;
    import cpu_datapath_pkg::*;
    logic clock = 1'b0;
    logic clear;
    cpu_datapath_if dp();
    cpu_datapath u_dut (.clock(clock), .clear(clear), .dp(dp));
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    word_t m_r [16];
    word_t m_pc, m_hi, m_lo, m_mar, m_mdr, m_y, m_inp;
    logic [63:0] m_z;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_pc = '0; m_hi = '0; m_lo = '0; m_mar = '0; m_mdr = '0; m_y = '0; m_inp = '0; m_z = '0;
    endfunction

    function automatic word_t model_bus();
        for (int i = 0; i < 16; i++) if (dp.r_out[i]) return m_r[i];
        if (dp.hi_out) return m_hi;
        if (dp.lo_out) return m_lo;
        if (dp.z_high_out) return m_z[63:32];
        if (dp.z_low_out) return m_z[31:0];
        if (dp.pc_out) return m_pc;
        if (dp.mdr_out) return m_mdr;
        if (dp.in_port_out) return m_inp;
        return '0;
    endfunction

    function automatic logic [63:0] model_alu(input logic [4:0] op, input word_t a, input word_t b);
        int unsigned s = b[4:0];
        int sa = a;
        int sb = b;
        case (op)
            OP_ADD:  return {32'd0, a + b};
            OP_SUB:  return {32'd0, a - b};
            OP_AND:  return {32'd0, a & b};
            OP_OR:   return {32'd0, a | b};
            OP_SHR:  return {32'd0, a >> s};
            OP_SHRA: return {32'd0, word_t'(sa >>> s)};
            OP_SHL:  return {32'd0, a << s};
            OP_ROR:  return {32'd0, word_t'((a >> s) | (a << (32 - s)))};
            OP_ROL:  return {32'd0, word_t'((a << s) | (a >> (32 - s)))};
            OP_MUL:  return longint'(sa) * longint'(sb);
            OP_DIV:  return (sb == 0) ? 64'd0 : {word_t'(sa % sb), word_t'(sa / sb)};
            OP_NEG:  return {32'd0, word_t'(-sb)};
            OP_NOT:  return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    task automatic idle();
        dp.r_in = '0; dp.r_out = '0; dp.opcode = '0; dp.read = 1'b0;
        dp.pc_in = 1'b0; dp.hi_in = 1'b0; dp.lo_in = 1'b0; dp.mar_in = 1'b0; dp.y_in = 1'b0;
        dp.z_in = 1'b0; dp.mdr_in = 1'b0; dp.inc_pc = 1'b0; dp.in_port_in = 1'b0;
        dp.pc_out = 1'b0; dp.hi_out = 1'b0; dp.lo_out = 1'b0; dp.mdr_out = 1'b0;
        dp.in_port_out = 1'b0; dp.z_high_out = 1'b0; dp.z_low_out = 1'b0;
    endtask

    // one register-transfer step: check the bus, then advance the model and the DUT by one edge
    task automatic tick();
        word_t b;
        #1;
        b = model_bus();
        check("bus", dp.bus_mux_out, b);
        if (dp.z_in) m_z = model_alu(dp.opcode, m_y, b);
        for (int i = 0; i < 16; i++) if (dp.r_in[i]) m_r[i] = b;
        if (dp.pc_in) m_pc = b;
        else if (dp.inc_pc) m_pc = m_pc + 1;
        if (dp.hi_in) m_hi = b;
        if (dp.lo_in) m_lo = b;
        if (dp.mar_in) m_mar = b;
        if (dp.y_in) m_y = b;
        if (dp.mdr_in) m_mdr = dp.read ? dp.mdatain : b;
        if (dp.in_port_in) m_inp = dp.in_port_data;
        @(posedge clock);
        #1;
        check("mar", dp.mar_out, m_mar);
        idle();
    endtask

    task automatic peek(input string tag, input word_t exp);
        #1;
        check(tag, dp.bus_mux_out, exp);
        idle();
    endtask

    task automatic load_r(input int idx, input word_t val);
        dp.mdatain = val; dp.read = 1'b1; dp.mdr_in = 1'b1;
        tick();
        dp.mdr_out = 1'b1; dp.r_in[idx] = 1'b1;
        tick();
    endtask

    task automatic alu_op(input logic [4:0] op, input int ra, input int rb, input int rd);
        dp.r_out[ra] = 1'b1; dp.y_in = 1'b1;
        tick();
        dp.r_out[rb] = 1'b1; dp.opcode = op; dp.z_in = 1'b1;
        tick();
        dp.z_low_out = 1'b1; dp.r_in[rd] = 1'b1;
        tick();
    endtask

    logic [4:0] sh_ops [5] = '{OP_SHR, OP_SHRA, OP_ROL, OP_ROR, 5'b11010};
    word_t      sh_exp [5] = '{32'h40000000, 32'hC0000000, 32'h00000003, 32'hC0000000, 32'h0};
    logic [4:0] op_tbl [13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                                OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT};

    initial begin
        idle();
        dp.mdatain = '0; dp.in_port_data = '0;
        clear = 1'b0;
        model_reset();
        #12;
        check("rst_bus", dp.bus_mux_out, 0);
        check("rst_mar", dp.mar_out, 0);
        clear = 1'b1;
        @(posedge clock);
        #1;
        dp.pc_out = 1'b1; dp.mar_in = 1'b1; dp.inc_pc = 1'b1;
        tick();
        check("fetch_mar", dp.mar_out, 0);
        dp.pc_out = 1'b1;
        peek("fetch_pc_inc", 1);
        dp.pc_in = 1'b1;
        tick();
        dp.pc_out = 1'b1;
        peek("pc_load_zero", 0);
        load_r(3, 10);
        load_r(7, 22);
        alu_op(OP_AND, 3, 7, 4);
        dp.r_out[4] = 1'b1;
        peek("and_r4", 2);
        dp.z_high_out = 1'b1;
        peek("and_zhigh", 0);
        load_r(6, 30);
        load_r(7, 25);
        alu_op(OP_ADD, 6, 7, 5);
        dp.r_out[5] = 1'b1;
        peek("add_r5", 55);
        alu_op(OP_SUB, 6, 7, 5);
        dp.r_out[5] = 1'b1;
        peek("sub_r5", 5);
        load_r(1, 32'h00010000);
        alu_op(OP_MUL, 1, 1, 2);
        dp.z_high_out = 1'b1; dp.hi_in = 1'b1;
        tick();
        dp.z_low_out = 1'b1; dp.lo_in = 1'b1;
        tick();
        dp.hi_out = 1'b1;
        peek("mul_hi", 1);
        dp.lo_out = 1'b1;
        peek("mul_lo", 0);
        load_r(1, 25);
        load_r(2, 7);
        alu_op(OP_DIV, 1, 2, 3);
        dp.r_out[3] = 1'b1;
        peek("div_quo", 3);
        dp.z_high_out = 1'b1;
        peek("div_rem", 4);
        load_r(2, 0);
        alu_op(OP_DIV, 1, 2, 3);
        dp.z_low_out = 1'b1;
        peek("div0_lo", 0);
        dp.z_high_out = 1'b1;
        peek("div0_hi", 0);
        load_r(1, 32'h80000001);
        load_r(2, 1);
        for (int k = 0; k < 5; k++) begin
            alu_op(sh_ops[k], 1, 2, 3);
            dp.r_out[3] = 1'b1;
            peek($sformatf("shift_op%0d", sh_ops[k]), sh_exp[k]);
        end
        dp.z_high_out = 1'b1;
        peek("bad_op_zhigh", 0);
        // same-register drive and load: bus shows old value, register captures it
        dp.r_out[1] = 1'b1; dp.r_in[1] = 1'b1;
        tick();
        dp.r_out[1] = 1'b1;
        peek("self_xfer", 32'h80000001);
        load_r(3, 10);
        dp.r_out[3] = 1'b1; dp.mar_in = 1'b1; dp.inc_pc = 1'b1;
        tick();
        alu_op(OP_ADD, 3, 3, 4);
        #2;
        clear = 1'b0;
        model_reset();
        #1;
        check("async_mar", dp.mar_out, 0);
        dp.r_out[3] = 1'b1;
        peek("async_r3", 0);
        dp.pc_out = 1'b1;
        peek("async_pc", 0);
        dp.z_low_out = 1'b1;
        peek("async_zlo", 0);
        peek("async_nodrv", 0);
        clear = 1'b1;
        @(posedge clock);
        #1;
        for (int n = 0; n < 400; n++) begin
            dp.r_in = 16'($urandom & $urandom);
            dp.r_out = 16'($urandom & $urandom & $urandom);
            dp.pc_in = ($urandom_range(0, 5) == 0); dp.inc_pc = ($urandom_range(0, 3) == 0);
            dp.hi_in = ($urandom_range(0, 3) == 0); dp.lo_in = ($urandom_range(0, 3) == 0);
            dp.mar_in = ($urandom_range(0, 3) == 0); dp.y_in = ($urandom_range(0, 2) == 0);
            dp.z_in = ($urandom_range(0, 1) == 0); dp.mdr_in = ($urandom_range(0, 2) == 0);
            dp.read = ($urandom_range(0, 1) == 0); dp.in_port_in = ($urandom_range(0, 3) == 0);
            dp.pc_out = ($urandom_range(0, 7) == 0); dp.hi_out = ($urandom_range(0, 7) == 0);
            dp.lo_out = ($urandom_range(0, 7) == 0); dp.mdr_out = ($urandom_range(0, 5) == 0);
            dp.in_port_out = ($urandom_range(0, 5) == 0);
            dp.z_high_out = ($urandom_range(0, 7) == 0); dp.z_low_out = ($urandom_range(0, 5) == 0);
            dp.mdatain = $urandom; dp.in_port_data = $urandom;
            dp.opcode = $urandom_range(0, 3) != 0 ? op_tbl[$urandom_range(0, 12)] : 5'($urandom);
            if (dp.opcode == OP_DIV && m_y == 32'h80000000 && model_bus() == 32'hFFFFFFFF)
                dp.opcode = OP_ADD;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- 32-bit single-bus CPU datapath.
- Contains 16 general registers R0–R15, PC, HI, LO, MAR, MDR, Y, a 64-bit Z register, an input-port register and a combinational ALU.
- All transfers pass through one shared 32-bit bus built by a one-hot-select multiplexer.
- The external control unit (or a testbench) drives every load/drive strobe and the opcode, one register-transfer step per clock.

Parameters:
- WIDTH, 32, data/bus width; all registers are WIDTH bits except Z, which is 2*WIDTH.

Ports:
- clock  in  1  system clock; rising-edge active.
- clear  in  1  asynchronous, active-low reset.
- R0in..R15in  in  1 each  load the GP register from the bus.
- PCin, HIin, LOin, MARin, Yin  in  1 each  load the named register from the bus.
- Zin  in  1  load Z[63:0] from the ALU result.
- MDRin  in  1  load MDR.
- read  in  1  MDR source select: 1 = Mdatain, 0 = bus.
- incPC  in  1  PC <= PC+1.
- InPortIn  in  1  load the input-port register from InPortData.
- InPortData  in  32  external input-port value.
- opcode  in  5  ALU operation select.
- Mdatain  in  32  memory read data.
- R0out..R15out  in  1 each  drive the GP register onto the bus.
- PCout, HIout, LOout, MDRout, InPortOut  in  1 each  drive the named register onto the bus.
- ZHighOut, ZLowOut  in  1 each  drive Z[63:32] or Z[31:0] onto the bus.
- BusMuxOut  out  32  current bus value (observability).
- MARout  out  32  MAR contents (memory address).

Behaviour:
- Reset: while clear=0, every register (R0–R15, PC, HI, LO, MAR, MDR, Y, Z, InPort) is 0, asynchronously. Consequently MARout=0 and BusMuxOut=0.
- All register loads are synchronous on the rising clock edge when the enable is 1. Otherwise the register holds.
- Bus multiplexer is combinational. Drive selects are expected one-hot.
  - If several are high, a fixed priority applies: R0..R15, HI, LO, ZHigh, ZLow, PC, MDR, InPort.
  - If none is high, the bus is 0.
- MDR input = read ? Mdatain : bus. MDR loads only when MDRin=1.
- PC: PCin has priority over incPC. incPC alone gives PC <= PC+1, wrapping at 2^32.
- ALU: A = Y, B = bus. The result is 64 bits and is registered into Z only when Zin=1. Opcodes:
  - 00011 add: low = A+B, high = 0 (carry discarded).
  - 00100 sub: low = A−B, high = 0.
  - 00101 and: low = A&B, high = 0.
  - 00110 or: low = A|B, high = 0.
  - 00111 shr: low = A >> B[4:0], logical.
  - 01000 shra: low = A >>> B[4:0], arithmetic.
  - 01001 shl: low = A << B[4:0].
  - 01010 ror / 01011 rol: rotate A by B[4:0].
  - 01111 mul: Z = signed A*B, full 64 bits.
  - 10000 div: low = signed A/B (quotient), high = remainder (sign follows dividend). If B=0, Z = 0.
  - 10001 neg: low = −B.
  - 10010 not: low = ~B.
  - Any other opcode (e.g. 11010): Z result = 0.
- For all non-mul/div ops, high = 0.
- Latency: a Y/ALU/Z operation takes one edge after operands are present. A three-step sequence (Yin; operand + Zin; ZLowOut + Rxin) completes in 3 clocks.
- Simultaneous load and drive of the same register: the bus shows the old value, and the register captures the bus value at the edge.
- Reset asserted mid-sequence clears everything immediately. Operation resumes from zero state once clear=1.

Decomposition:
- Shared package holds:
  - WIDTH.
  - 5-bit opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT).
- Sub-modules:
  - One natural sub-module, cpu_alu: combinational; A, B, opcode in; 64-bit result out.
  - One generic register, enable + async active-low clear, instantiated for all 32-bit registers.

Test Plan:
- AND: load R3=10 and R7=22 via Mdatain/read/MDRin then MDRout/Rxin. Then R3out+Yin; R7out, opcode 00101, Zin; ZLowOut+R4in. -> R4 = 2, Z[63:32] = 0.
- ADD: R6=30, R7=25, opcode 00011 -> Zlow = 55, written to R5. SUB with the same operands -> 5.
- Fetch step: PCout+MARin+incPC with PC=0 -> MARout = 0 and PC = 1 after one edge. PCin with the bus=0 (no drivers) on the next cycle -> PC = 0.
- MUL/DIV: Y = 0x00010000, bus = 0x00010000, mul -> Z = 0x0000000100000000. Then ZHighOut→HIin and ZLowOut→LOin give HI = 1, LO = 0. Div 25/7 -> Zlow = 3, Zhigh = 4. Div by 0 -> Z = 0.
- Shifts/rotates: Y = 0x80000001, B = 1: shr -> 0x40000000; shra -> 0xC0000000; rol -> 0x00000003; ror -> 0xC0000000. Opcode 11010 -> Z = 0.
- Reset: assert clear=0 mid-sequence after loading R3 = 10 -> R3, PC, Z, MAR = 0 immediately without waiting for a clock edge. No drivers -> BusMuxOut = 0.
